// File: rtl/ahbl_arbiter_rr.sv
// Round-robin N:1 AHB-Lite arbiter with per-port address-phase buffers
// and HMASTLOCK ownership; the winner passes through with no added latency.
module ahbl_arbiter_rr #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORTS-1:0]        src_hready,
  output logic [N_PORTS-1:0]        src_hready_resp,
  output logic [N_PORTS-1:0]        src_hresp,
  input  logic [N_PORTS*W_ADDR-1:0] src_haddr,
  input  logic [N_PORTS-1:0]        src_hwrite,
  input  logic [N_PORTS*2-1:0]      src_htrans,
  input  logic [N_PORTS*3-1:0]      src_hsize,
  input  logic [N_PORTS-1:0]        src_hmastlock,
  input  logic [N_PORTS*W_DATA-1:0] src_hwdata,
  output logic [N_PORTS*W_DATA-1:0] src_hrdata,
  output logic                      dst_hready,
  input  logic                      dst_hready_resp,
  input  logic                      dst_hresp,
  output logic [W_ADDR-1:0]         dst_haddr,
  output logic                      dst_hwrite,
  output logic [1:0]                dst_htrans,
  output logic [2:0]                dst_hsize,
  output logic                      dst_hmastlock,
  output logic [W_DATA-1:0]         dst_hwdata,
  input  logic [W_DATA-1:0]         dst_hrdata
);

  localparam int PW = (N_PORTS > 2) ? $clog2(N_PORTS) : 1;

  logic [W_ADDR-1:0]  live_addr [N_PORTS];
  logic [1:0]         live_trans [N_PORTS];
  logic [2:0]         live_size [N_PORTS];
  logic [N_PORTS-1:0] live_req;

  logic [W_ADDR-1:0]  eff_addr [N_PORTS];
  logic [1:0]         eff_trans [N_PORTS];
  logic [2:0]         eff_size [N_PORTS];
  logic [N_PORTS-1:0] eff_write;
  logic [N_PORTS-1:0] eff_lock;
  logic [N_PORTS-1:0] req;

  logic [N_PORTS-1:0] buf_vld_q, buf_vld_d;
  logic [W_ADDR-1:0]  buf_addr_q [N_PORTS];
  logic [W_ADDR-1:0]  buf_addr_d [N_PORTS];
  logic [1:0]         buf_trans_q [N_PORTS];
  logic [1:0]         buf_trans_d [N_PORTS];
  logic [2:0]         buf_size_q [N_PORTS];
  logic [2:0]         buf_size_d [N_PORTS];
  logic [N_PORTS-1:0] buf_write_q, buf_write_d;
  logic [N_PORTS-1:0] buf_lock_q, buf_lock_d;

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [N_PORTS-1:0] dph_q, dph_d;
  logic               lock_vld_q, lock_vld_d;
  logic [PW-1:0]      lock_own_q, lock_own_d;

  logic [N_PORTS-1:0] gnt;
  logic [PW-1:0]      gidx;
  logic               gnt_vld;
  logic               accept;
  logic               own_smp;
  logic               own_lock;
  logic               found;
  int                 idx;

  // A pending buffer always overrides the live bus of that port
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      live_addr[i]  = src_haddr[i*W_ADDR +: W_ADDR];
      live_trans[i] = src_htrans[i*2 +: 2];
      live_size[i]  = src_hsize[i*3 +: 3];
      live_req[i]   = src_htrans[i*2+1] & src_hready[i];
      eff_addr[i]   = buf_vld_q[i] ? buf_addr_q[i] : live_addr[i];
      eff_trans[i]  = buf_vld_q[i] ? buf_trans_q[i] : live_trans[i];
      eff_size[i]   = buf_vld_q[i] ? buf_size_q[i] : live_size[i];
      eff_write[i]  = buf_vld_q[i] ? buf_write_q[i] : src_hwrite[i];
      eff_lock[i]   = buf_vld_q[i] ? buf_lock_q[i] : src_hmastlock[i];
      req[i]        = buf_vld_q[i] | live_req[i];
    end
  end

  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (lock_vld_q) begin
      if (req[lock_own_q]) begin
        gnt[lock_own_q] = 1'b1;
        gidx            = lock_own_q;
      end
    end else begin
      for (int k = 0; k < N_PORTS; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N_PORTS) idx = idx - N_PORTS;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gidx     = PW'(idx);
        end
      end
    end
  end

  assign gnt_vld  = |gnt;
  assign accept   = dst_hready_resp & gnt_vld;
  assign own_smp  = buf_vld_q[lock_own_q] | src_hready[lock_own_q];
  assign own_lock = eff_lock[lock_own_q];

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gidx == PW'(N_PORTS - 1)) ? '0 : gidx + PW'(1);
    end
    dph_d = dst_hready_resp ? gnt : dph_q;
  end

  // Owner keeps the bus until it completes an address phase without lock
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    if (lock_vld_q && dst_hready_resp && own_smp && !own_lock) begin
      lock_vld_d = 1'b0;
    end
    if (accept && eff_lock[gidx]) begin
      lock_vld_d = 1'b1;
      lock_own_d = gidx;
    end
  end

  always_comb begin
    buf_vld_d   = buf_vld_q;
    buf_write_d = buf_write_q;
    buf_lock_d  = buf_lock_q;
    for (int i = 0; i < N_PORTS; i++) begin
      buf_addr_d[i]  = buf_addr_q[i];
      buf_trans_d[i] = buf_trans_q[i];
      buf_size_d[i]  = buf_size_q[i];
      if (buf_vld_q[i]) begin
        if (accept && gnt[i]) buf_vld_d[i] = 1'b0;
      end else if (live_req[i] && !(accept && gnt[i])) begin
        buf_vld_d[i]   = 1'b1;
        buf_addr_d[i]  = live_addr[i];
        buf_trans_d[i] = live_trans[i];
        buf_size_d[i]  = live_size[i];
        buf_write_d[i] = src_hwrite[i];
        buf_lock_d[i]  = src_hmastlock[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld_q   <= '0;
      buf_write_q <= '0;
      buf_lock_q  <= '0;
      for (int i = 0; i < N_PORTS; i++) begin
        buf_addr_q[i]  <= '0;
        buf_trans_q[i] <= '0;
        buf_size_q[i]  <= '0;
      end
      ptr_q      <= '0;
      dph_q      <= '0;
      lock_vld_q <= 1'b0;
      lock_own_q <= '0;
    end else begin
      buf_vld_q   <= buf_vld_d;
      buf_write_q <= buf_write_d;
      buf_lock_q  <= buf_lock_d;
      for (int i = 0; i < N_PORTS; i++) begin
        buf_addr_q[i]  <= buf_addr_d[i];
        buf_trans_q[i] <= buf_trans_d[i];
        buf_size_q[i]  <= buf_size_d[i];
      end
      ptr_q      <= ptr_d;
      dph_q      <= dph_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
    end
  end

  // An idle lock owner still holds HMASTLOCK on the shared bus
  always_comb begin
    dst_haddr     = '0;
    dst_hwrite    = 1'b0;
    dst_htrans    = 2'b00;
    dst_hsize     = 3'b000;
    dst_hmastlock = 1'b0;
    if (gnt_vld) begin
      dst_haddr     = eff_addr[gidx];
      dst_hwrite    = eff_write[gidx];
      dst_htrans    = eff_trans[gidx];
      dst_hsize     = eff_size[gidx];
      dst_hmastlock = eff_lock[gidx];
    end else if (lock_vld_q) begin
      dst_hmastlock = own_lock;
    end
  end

  always_comb begin
    dst_hwdata = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (dph_q[i]) dst_hwdata = src_hwdata[i*W_DATA +: W_DATA];
      src_hready_resp[i] = dph_q[i] ? dst_hready_resp : ~buf_vld_q[i];
      src_hresp[i]       = dph_q[i] & dst_hresp;
    end
  end

  assign dst_hready = dst_hready_resp;
  assign src_hrdata = {N_PORTS{dst_hrdata}};

endmodule

// File: tb/tb_ahbl_arbiter_rr.sv
// Directed bench for ahbl_arbiter_rr: one vector per clock cycle,
// compared on the falling edge.
module tb_ahbl_arbiter_rr;

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] ID = 2'b00;
  localparam logic [31:0] WD0 = 32'hD0D0_0000;
  localparam logic [31:0] WD1 = 32'hD1D1_1111;
  localparam logic [31:0] RD  = 32'h5A5A_A5A5;

  typedef struct {
    logic [1:0]  t0, t1;
    logic [31:0] a0, a1;
    logic [1:0]  lk, hr;
    logic        sr, se;
    logic [1:0]  et;
    logic [31:0] ea;
    logic        el;
    logic [1:0]  er, es;
    logic [31:0] ew;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  src_hready, src_hready_resp, src_hresp;
  logic [63:0] src_haddr;
  logic [1:0]  src_hwrite;
  logic [3:0]  src_htrans;
  logic [5:0]  src_hsize;
  logic [1:0]  src_hmastlock;
  logic [63:0] src_hwdata, src_hrdata;
  logic        dst_hready, dst_hready_resp, dst_hresp;
  logic [31:0] dst_haddr;
  logic        dst_hwrite;
  logic [1:0]  dst_htrans;
  logic [2:0]  dst_hsize;
  logic        dst_hmastlock;
  logic [31:0] dst_hwdata, dst_hrdata;

  int checks = 0;
  int fails  = 0;
  vec_t tbl [16];

  ahbl_arbiter_rr #(.N_PORTS(2), .W_ADDR(32), .W_DATA(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_hready(src_hready), .src_hready_resp(src_hready_resp),
    .src_hresp(src_hresp), .src_haddr(src_haddr),
    .src_hwrite(src_hwrite), .src_htrans(src_htrans),
    .src_hsize(src_hsize), .src_hmastlock(src_hmastlock),
    .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
    .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp),
    .dst_hresp(dst_hresp), .dst_haddr(dst_haddr),
    .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
    .dst_hsize(dst_hsize), .dst_hmastlock(dst_hmastlock),
    .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(
    input logic [1:0] t0, input logic [31:0] a0,
    input logic [1:0] t1, input logic [31:0] a1,
    input logic [1:0] lk, input logic [1:0] hr,
    input logic sr, input logic se,
    input logic [1:0] et, input logic [31:0] ea,
    input logic el, input logic [1:0] er,
    input logic [1:0] es, input logic [31:0] ew);
    vec_t v;
    v.t0 = t0; v.a0 = a0; v.t1 = t1; v.a1 = a1;
    v.lk = lk; v.hr = hr; v.sr = sr; v.se = se;
    v.et = et; v.ea = ea; v.el = el;
    v.er = er; v.es = es; v.ew = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input vec_t v);
    chk({nm, ".htrans"}, 32'(dst_htrans), 32'(v.et));
    chk({nm, ".haddr"}, dst_haddr, v.ea);
    chk({nm, ".hmastlock"}, 32'(dst_hmastlock), 32'(v.el));
    chk({nm, ".hready_resp"}, 32'(src_hready_resp), 32'(v.er));
    chk({nm, ".hresp"}, 32'(src_hresp), 32'(v.es));
    chk({nm, ".hwdata"}, dst_hwdata, v.ew);
  endtask

  task automatic drive(input vec_t v);
    src_htrans      = {v.t1, v.t0};
    src_haddr       = {v.a1, v.a0};
    src_hmastlock   = v.lk;
    src_hready      = v.hr;
    dst_hready_resp = v.sr;
    dst_hresp       = v.se;
  endtask

  task automatic apply(input string nm, input vec_t v);
    drive(v);
    @(negedge clk);
    check_out(nm, v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    idle = mk(ID, 0, ID, 0, 2'b00, 2'b11, 1'b1, 1'b0,
              ID, 0, 1'b0, 2'b11, 2'b00, 32'h0);
    src_hwrite = 2'b00;
    src_hsize  = 6'b010_010;
    src_hwdata = {WD1, WD0};
    dst_hrdata = RD;
    rst_n = 1'b0;
    drive(idle);
    dst_hresp = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out("reset", idle);
    chk("hrdata", src_hrdata[63:32], RD);
    rst_n = 1'b1;
    dst_hresp = 1'b0;
    @(posedge clk);
    #1;

    // Contention after reset, then continuous streaming from both ports
    tbl[0]  = mk(NS, 'h10, NS, 'h20, 0, 2'b11, 1, 0, NS, 'h10, 0, 2'b11, 0, 0);
    tbl[1]  = mk(ID, 0, NS, 'h20, 0, 2'b01, 1, 0, NS, 'h20, 0, 2'b01, 0, WD0);
    tbl[2]  = mk(ID, 0, ID, 0, 0, 2'b11, 1, 0, ID, 0, 0, 2'b11, 0, WD1);
    tbl[3]  = mk(NS, 'h30, NS, 'h40, 0, 2'b11, 1, 0, NS, 'h30, 0, 2'b11, 0, 0);
    tbl[4]  = mk(NS, 'h50, NS, 'h40, 0, 2'b01, 1, 0, NS, 'h40, 0, 2'b01, 0, WD0);
    tbl[5]  = mk(NS, 'h50, NS, 'h60, 0, 2'b10, 1, 0, NS, 'h50, 0, 2'b10, 0, WD1);
    tbl[6]  = mk(NS, 'h70, NS, 'h60, 0, 2'b01, 1, 0, NS, 'h60, 0, 2'b01, 0, WD0);
    tbl[7]  = mk(NS, 'h70, NS, 'h80, 0, 2'b10, 1, 0, NS, 'h70, 0, 2'b10, 0, WD1);
    tbl[8]  = mk(NS, 'h90, NS, 'h80, 0, 2'b01, 1, 0, NS, 'h80, 0, 2'b01, 0, WD0);
    tbl[9]  = mk(NS, 'h90, NS, 'hA0, 0, 2'b10, 1, 0, NS, 'h90, 0, 2'b10, 0, WD1);
    tbl[10] = mk(ID, 0, NS, 'hA0, 0, 2'b01, 1, 0, NS, 'hA0, 0, 2'b01, 0, WD0);
    tbl[11] = mk(ID, 0, ID, 0, 0, 2'b11, 1, 0, ID, 0, 0, 2'b11, 0, WD1);
    tbl[12] = mk(ID, 0, ID, 0, 0, 2'b11, 1, 0, ID, 0, 0, 2'b11, 0, 0);
    tbl[13] = mk(NS, 'h100, ID, 0, 0, 2'b11, 1, 0, NS, 'h100, 0, 2'b11, 0, 0);
    tbl[14] = mk(ID, 0, ID, 0, 0, 2'b10, 0, 0, ID, 0, 0, 2'b10, 0, WD0);
    tbl[15] = mk(ID, 0, ID, 0, 0, 2'b11, 1, 0, ID, 0, 0, 2'b11, 0, WD0);
    for (int k = 0; k < 16; k++) apply($sformatf("v%0d", k), tbl[k]);

    // Wait states on port0 data phase with port1 buffered
    apply("w0", mk(NS, 'h300, ID, 0, 0, 2'b11, 1, 0, NS, 'h300, 0, 2'b11, 0, 0));
    apply("w1", mk(ID, 0, NS, 'h44, 0, 2'b10, 0, 0, NS, 'h44, 0, 2'b10, 0, WD0));
    apply("w2", mk(ID, 0, NS, 'h44, 0, 2'b00, 0, 0, NS, 'h44, 0, 2'b00, 0, WD0));
    apply("w3", mk(ID, 0, NS, 'h44, 0, 2'b01, 1, 0, NS, 'h44, 0, 2'b01, 0, WD0));
    apply("w4", mk(ID, 0, ID, 0, 0, 2'b01, 0, 0, ID, 0, 0, 2'b01, 0, WD1));
    apply("w5", mk(ID, 0, ID, 0, 0, 2'b11, 1, 0, ID, 0, 0, 2'b11, 0, WD1));

    // Locked sequence from port1 while port0 waits
    apply("l0", mk(ID, 0, NS, 'h500, 2'b10, 2'b11, 1, 0, NS, 'h500, 1, 2'b11, 0, 0));
    apply("l1", mk(NS, 'h600, NS, 'h504, 2'b10, 2'b11, 1, 0, NS, 'h504, 1, 2'b11, 0, WD1));
    apply("l2", mk(NS, 'h600, NS, 'h508, 2'b10, 2'b10, 1, 0, NS, 'h508, 1, 2'b10, 0, WD1));
    apply("l3", mk(NS, 'h600, ID, 0, 2'b10, 2'b10, 1, 0, ID, 0, 1, 2'b10, 0, WD1));
    apply("l4", mk(NS, 'h600, NS, 'h50C, 2'b00, 2'b10, 1, 0, NS, 'h50C, 0, 2'b10, 0, 0));
    apply("l5", mk(NS, 'h600, ID, 0, 2'b00, 2'b10, 1, 0, NS, 'h600, 0, 2'b10, 0, WD1));
    apply("l6", mk(ID, 0, ID, 0, 2'b00, 2'b11, 1, 0, ID, 0, 0, 2'b11, 0, WD0));

    // Two-cycle ERROR response on port0
    apply("e0", mk(NS, 'h700, ID, 0, 0, 2'b11, 1, 0, NS, 'h700, 0, 2'b11, 0, 0));
    apply("e1", mk(ID, 0, ID, 0, 0, 2'b10, 0, 1, ID, 0, 0, 2'b10, 2'b01, WD0));
    apply("e2", mk(ID, 0, ID, 0, 0, 2'b11, 1, 1, ID, 0, 0, 2'b11, 2'b01, WD0));
    apply("e3", mk(NS, 'h704, NS, 'h800, 0, 2'b11, 1, 0, NS, 'h800, 0, 2'b11, 0, 0));

    // Asynchronous reset with port1 in data phase and port0 buffered
    drive(idle);
    dst_hready_resp = 1'b0;
    dst_hresp = 1'b1;
    #1;
    chk("pre_rst.hresp", 32'(src_hresp), 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    check_out("mid_rst", idle);
    @(negedge clk);
    rst_n = 1'b1;
    dst_hresp = 1'b0;
    dst_hready_resp = 1'b1;
    @(posedge clk);
    #1;
    apply("r0", idle);
    apply("r1", mk(NS, 'h10, NS, 'h20, 0, 2'b11, 1, 0, NS, 'h10, 0, 2'b11, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
